// File: rtl/phase_sequencer.sv
// Machine-cycle phase sequencer: registered PH1/PH2 pulses with run/halt/step,
// memory wait states and stuck-bus timeout. Optional counter: CYCLE_COUNT_EN.
module phase_sequencer #(
    parameter int GAP      = 1,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             READY,
    output logic             PH1,
    output logic             PH2,
    output logic             SYNC,
    output logic             O_S,
    output logic             HALTED,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] CYC_CNT
);

    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [2:0] GAP_LOAD = 3'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {HALT, P1, G1, WAIT, P2, G2} stateT;

    stateT          state;
    stateT          nextState;
    stateT          p2Entry;
    stateT          cycleNext;
    logic [2:0]     gapCnt;
    logic [WW-1:0]  waitCnt;
    logic           stepMode;
    logic           endCycle;
    logic           timeoutHit;

    always_comb begin
        nextState  = state;
        endCycle   = 1'b0;
        timeoutHit = 1'b0;
        p2Entry    = READY ? P2 : WAIT;
        cycleNext  = (RUN && !stepMode) ? P1 : HALT;
        unique case (state)
            HALT: if (RUN || STEP) nextState = P1;
            P1:   nextState = (GAP == 0) ? p2Entry : G1;
            G1:   if (gapCnt == '0) nextState = p2Entry;
            WAIT: begin
                if (READY) begin
                    nextState = P2;
                end else if (WAIT_MAX != 0 && waitCnt == WW'(WAIT_MAX - 1)) begin
                    // Stuck bus: abandon the cycle without counting it
                    timeoutHit = 1'b1;
                    nextState  = HALT;
                end
            end
            P2: begin
                if (GAP == 0) begin
                    endCycle  = 1'b1;
                    nextState = cycleNext;
                end else begin
                    nextState = G2;
                end
            end
            G2: begin
                if (gapCnt == '0) begin
                    endCycle  = 1'b1;
                    nextState = cycleNext;
                end
            end
            default: nextState = HALT;
        endcase
    end

    // Outputs are decoded from nextState so each pulse lines up with its state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= HALT;
            gapCnt   <= '0;
            waitCnt  <= '0;
            stepMode <= 1'b0;
            PH1      <= 1'b0;
            PH2      <= 1'b0;
            SYNC     <= 1'b0;
            O_S      <= 1'b1;
            HALTED   <= 1'b1;
            TIMEOUT  <= 1'b0;
        end else begin
            state  <= nextState;
            PH1    <= (nextState == P1);
            SYNC   <= (nextState == P1);
            PH2    <= (nextState == P2);
            HALTED <= (nextState == HALT);

            if ((nextState == G1 || nextState == G2) && nextState != state)
                gapCnt <= GAP_LOAD;
            else if (gapCnt != '0)
                gapCnt <= gapCnt - 3'd1;

            waitCnt <= (state == WAIT && nextState == WAIT) ? waitCnt + WW'(1) : '0;

            if (state == HALT && nextState == P1)
                stepMode <= !RUN;

            if (endCycle)
                O_S <= ~O_S;

            if (timeoutHit)
                TIMEOUT <= 1'b1;
            else if (state == HALT && nextState != HALT)
                TIMEOUT <= 1'b0;
        end
    end

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            CYC_CNT <= '0;
        else if (endCycle)
            CYC_CNT <= CYC_CNT + CNT_W'(1);
    end
`else
    assign CYC_CNT = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed vector table, hand-written corner
// sequences, then random stimulus against a tick-position reference model.
module tb_phase_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    logic runA, stepA, readyA, runB, stepB, readyB;
    logic ph1A, ph2A, syncA, osA, haltedA, toA;
    logic ph1B, ph2B, syncB, osB, haltedB, toB;
    logic [7:0] cntA;
    logic [1:0] cntB;

    phase_sequencer #(.GAP(1), .WAIT_MAX(15), .CNT_W(8)) dutA (
        .CLK(CLK), .RST(RST), .RUN(runA), .STEP(stepA), .READY(readyA),
        .PH1(ph1A), .PH2(ph2A), .SYNC(syncA), .O_S(osA), .HALTED(haltedA),
        .TIMEOUT(toA), .CYC_CNT(cntA)
    );

    phase_sequencer #(.GAP(0), .WAIT_MAX(3), .CNT_W(2)) dutB (
        .CLK(CLK), .RST(RST), .RUN(runB), .STEP(stepB), .READY(readyB),
        .PH1(ph1B), .PH2(ph2B), .SYNC(syncB), .O_S(osB), .HALTED(haltedB),
        .TIMEOUT(toB), .CYC_CNT(cntB)
    );

`ifdef CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int expCnt(input int c);
        return CNT_EN ? c : 0;
    endfunction

    task automatic checkA(input string tag, input int p1, input int p2, input int h,
                          input int os, input int to, input int c);
        check({tag, ".ph1"}, int'(ph1A), p1);
        check({tag, ".sync"}, int'(syncA), p1);
        check({tag, ".ph2"}, int'(ph2A), p2);
        check({tag, ".halted"}, int'(haltedA), h);
        check({tag, ".os"}, int'(osA), os);
        check({tag, ".timeout"}, int'(toA), to);
        check({tag, ".cnt"}, int'(cntA), expCnt(c));
    endtask

    // Reference model: position within the machine cycle counted in ticks,
    // with wait ticks tracked separately.
    typedef struct {
        bit active;
        bit waiting;
        bit stepm;
        bit os;
        bit tmo;
        int pos;
        int waits;
        int cnt;
    } mdlT;

    function automatic mdlT mdlReset();
        mdlT s;
        s.active = 0; s.waiting = 0; s.stepm = 0; s.os = 1; s.tmo = 0;
        s.pos = 0; s.waits = 0; s.cnt = 0;
        return s;
    endfunction

    function automatic mdlT mdlStep(input mdlT s, input int gap, input int wm, input int cmod,
                                    input bit run, input bit step, input bit ready);
        mdlT n = s;
        if (!s.active) begin
            if (run || step) begin
                n.active = 1; n.pos = 0; n.waiting = 0; n.stepm = !run; n.tmo = 0;
            end
        end else if (s.waiting) begin
            if (ready) begin
                n.waiting = 0; n.pos = gap + 1; n.waits = 0;
            end else begin
                n.waits = s.waits + 1;
                if (wm != 0 && n.waits == wm) begin
                    n.tmo = 1; n.active = 0; n.waiting = 0; n.waits = 0;
                end
            end
        end else if (s.pos == gap) begin
            if (ready) n.pos = gap + 1;
            else begin n.waiting = 1; n.waits = 0; end
        end else if (s.pos == 2 * gap + 1) begin
            n.os  = !s.os;
            n.cnt = (s.cnt + 1) % cmod;
            if (run && !s.stepm) n.pos = 0;
            else n.active = 0;
        end else begin
            n.pos = s.pos + 1;
        end
        return n;
    endfunction

    task automatic cmpModel(input string tag, input mdlT s, input int gap,
                            input logic p1, input logic p2, input logic sy, input logic os,
                            input logic h, input logic to, input int c);
        int eP1, eP2;
        eP1 = (s.active && !s.waiting && s.pos == 0) ? 1 : 0;
        eP2 = (s.active && !s.waiting && s.pos == gap + 1) ? 1 : 0;
        check({tag, ".ph1"}, int'(p1), eP1);
        check({tag, ".sync"}, int'(sy), eP1);
        check({tag, ".ph2"}, int'(p2), eP2);
        check({tag, ".halted"}, int'(h), s.active ? 0 : 1);
        check({tag, ".os"}, int'(os), int'(s.os));
        check({tag, ".timeout"}, int'(to), int'(s.tmo));
        check({tag, ".cnt"}, c, expCnt(s.cnt));
    endtask

    typedef struct {
        bit run; bit step; bit ready;
        bit ph1; bit ph2; bit halted; bit os; int cnt;
    } vecT;

    function automatic vecT mk(input bit r, input bit s, input bit rd, input bit p1,
                               input bit p2, input bit h, input bit o, input int c);
        vecT v;
        v.run = r; v.step = s; v.ready = rd; v.ph1 = p1; v.ph2 = p2;
        v.halted = h; v.os = o; v.cnt = c;
        return v;
    endfunction

    vecT tbl[24];
    mdlT mA, mB;
    int lowBurst;

    initial begin
        // Free run, stop, single step, step ignored, RUN rising during step
        tbl[0]  = mk(1,0,1, 1,0,0,1,0);
        tbl[1]  = mk(1,0,1, 0,0,0,1,0);
        tbl[2]  = mk(1,0,1, 0,1,0,1,0);
        tbl[3]  = mk(1,0,1, 0,0,0,1,0);
        tbl[4]  = mk(1,0,1, 1,0,0,0,1);
        tbl[5]  = mk(1,0,1, 0,0,0,0,1);
        tbl[6]  = mk(1,0,1, 0,1,0,0,1);
        tbl[7]  = mk(1,0,1, 0,0,0,0,1);
        tbl[8]  = mk(1,0,1, 1,0,0,1,2);
        tbl[9]  = mk(1,0,1, 0,0,0,1,2);
        tbl[10] = mk(1,0,1, 0,1,0,1,2);
        tbl[11] = mk(1,0,1, 0,0,0,1,2);
        tbl[12] = mk(0,0,1, 0,0,1,0,3);
        tbl[13] = mk(0,1,1, 1,0,0,0,3);
        tbl[14] = mk(0,1,1, 0,0,0,0,3);
        tbl[15] = mk(1,0,1, 0,1,0,0,3);
        tbl[16] = mk(1,0,1, 0,0,0,0,3);
        tbl[17] = mk(1,0,1, 0,0,1,1,4);
        tbl[18] = mk(1,0,1, 1,0,0,1,4);
        tbl[19] = mk(0,0,1, 0,0,0,1,4);
        tbl[20] = mk(0,0,1, 0,1,0,1,4);
        tbl[21] = mk(0,0,1, 0,0,0,1,4);
        tbl[22] = mk(0,0,1, 0,0,1,0,5);
        tbl[23] = mk(0,0,1, 0,0,1,0,5);

        RST = 1'b0;
        runA = 0; stepA = 0; readyA = 1;
        runB = 0; stepB = 0; readyB = 1;
        repeat (2) @(posedge CLK);
        #1;
        checkA("reset", 0, 0, 1, 1, 0, 0);
        check("resetB.halted", int'(haltedB), 1);
        check("resetB.cnt", int'(cntB), 0);
        RST = 1'b1;

        for (int i = 0; i < 24; i++) begin
            runA = tbl[i].run; stepA = tbl[i].step; readyA = tbl[i].ready;
            tick();
            checkA($sformatf("vec%0d", i), tbl[i].ph1, tbl[i].ph2, tbl[i].halted,
                   tbl[i].os, 0, tbl[i].cnt);
        end
        stepA = 0;

        // Three wait ticks before PH2: period stretches from 4 to 7
        runA = 1; readyA = 1;
        tick(); checkA("wait.p1", 1, 0, 0, 0, 0, 5);
        tick(); checkA("wait.g1", 0, 0, 0, 0, 0, 5);
        readyA = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); checkA($sformatf("wait.w%0d", i), 0, 0, 0, 0, 0, 5);
        end
        readyA = 1;
        tick(); checkA("wait.p2", 0, 1, 0, 0, 0, 5);
        tick(); checkA("wait.g2", 0, 0, 0, 0, 0, 5);
        tick(); checkA("wait.period", 1, 0, 0, 1, 0, 6);
        runA = 0;
        repeat (3) tick();
        tick(); checkA("wait.halt", 0, 0, 1, 0, 0, 7);

        // Stuck bus: 15 wait ticks, then timeout and halt with cycle abandoned
        runA = 1; readyA = 0;
        tick(); tick(); tick();
        for (int i = 0; i < 14; i++) begin
            tick(); checkA($sformatf("tmo.w%0d", i), 0, 0, 0, 0, 0, 7);
        end
        tick(); checkA("tmo.hit", 0, 0, 1, 0, 1, 7);
        runA = 0; readyA = 1;
        tick(); checkA("tmo.sticky", 0, 0, 1, 0, 1, 7);
        runA = 1;
        tick(); checkA("tmo.clear", 1, 0, 0, 0, 0, 7);

        // Asynchronous reset in the middle of G1
        tick(); checkA("rst.g1", 0, 0, 0, 0, 0, 7);
        #2;
        RST = 1'b0;
        #1;
        checkA("rst.async", 0, 0, 1, 1, 0, 0);
        runA = 0;
        tick(); checkA("rst.hold", 0, 0, 1, 1, 0, 0);
        RST = 1'b1;

        // Random run/step/ready on both configurations against the model
        RST = 1'b0;
        tick();
        RST = 1'b1;
        mA = mdlReset();
        mB = mdlReset();
        lowBurst = 0;
        runA = 0; stepA = 0; readyA = 1;
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 19) == 0) runA = ~runA;
            stepA = ($urandom_range(0, 3) == 0);
            if (lowBurst > 0) begin
                lowBurst--;
                readyA = 0;
            end else if ($urandom_range(0, 11) == 0) begin
                lowBurst = $urandom_range(0, 19);
                readyA = 0;
            end else begin
                readyA = 1;
            end
            runB = runA; stepB = stepA; readyB = readyA;
            mA = mdlStep(mA, 1, 15, 256, runA, stepA, readyA);
            mB = mdlStep(mB, 0, 3, 4, runB, stepB, readyB);
            tick();
            cmpModel($sformatf("rndA%0d", t), mA, 1, ph1A, ph2A, syncA, osA, haltedA, toA, int'(cntA));
            cmpModel($sformatf("rndB%0d", t), mB, 0, ph1B, ph2B, syncB, osB, haltedB, toB, int'(cntB));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
